// File: rtl/pwm_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pwm_sched_pkg
// Purpose  : Shared defaults and derived constants for the PWM duty scheduler
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package pwm_sched_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_DUTY_WIDTH   = 8;
  localparam int DEF_PERIOD       = 192;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Occupancy needs one extra bit so a full FIFO (level == depth) is representable
  localparam int LEVEL_WIDTH      = $clog2(DEF_FIFO_DEPTH) + 1;

  // Half the period is the duty value that corresponds to a zero (silent) sample
  localparam int MIDSCALE_DUTY    = DEF_PERIOD / 2;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : sample_fifo
// Purpose  : Small synchronous FIFO; full/empty derived from the level count
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q,  level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (level_q == (PTR_W+1)'(DEPTH));
  assign w_empty   = (level_q == '0);
  // Requests against a full/empty FIFO are ignored rather than corrupting state
  assign w_do_push = push_i && !w_full;
  assign w_do_pop  = pop_i  && !w_empty;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pwm_duty_scheduler
// Purpose  : Buffers signed audio samples and hands a scaled duty value to
//            the PWM generator only at PWM period boundaries
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pwm_duty_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DUTY_WIDTH   = DEF_DUTY_WIDTH,
  parameter int PERIOD       = DEF_PERIOD,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [DUTY_WIDTH-1:0]         duty_cycle,
  output logic                          period_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          overflow,
  input  logic                          clear_flags
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int PW     = $clog2(PERIOD + 1);
  localparam int PROD_W = DUTY_WIDTH + PW;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_WIDTH-1:0] DUTY_MID = DUTY_WIDTH'(PERIOD / 2);
  localparam logic [PROD_W-1:0]     PERIOD_P = PROD_W'(PERIOD);

  logic [CNT_W-1:0]      cnt_q,          cnt_d;
  logic [DUTY_WIDTH-1:0] duty_q,         duty_d;
  logic                  period_start_q, period_start_d;
  logic                  underflow_q,    underflow_d;
  logic                  overflow_q,     overflow_d;

  logic                    w_boundary;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [SAMPLE_WIDTH-1:0] w_head;
  logic [SAMPLE_WIDTH-1:0] w_offset;
  logic [DUTY_WIDTH-1:0]   w_top;
  logic [PROD_W-1:0]       w_prod;

  // Readiness uses only registered FIFO state; a same-cycle pop does not free a slot
  assign sample_ready = !w_full;
  assign w_push       = sample_valid && !w_full;
  assign w_boundary   = enable && (cnt_q == CNT_LAST);
  assign w_pop        = w_boundary && !w_empty;

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (sample_in),
    .data_o  (w_head),
    .level_o (fifo_level),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Offset binary, keep the top bits, then scale into 0..PERIOD-1 with a full product
  assign w_offset = {~w_head[SAMPLE_WIDTH-1], w_head[SAMPLE_WIDTH-2:0]};
  assign w_top    = DUTY_WIDTH'(w_offset >> (SAMPLE_WIDTH - DUTY_WIDTH));
  assign w_prod   = PROD_W'(w_top) * PERIOD_P;

  // Next-state for counter, duty and sticky flags; a set event beats clear_flags
  always_comb begin
    cnt_d          = cnt_q;
    duty_d         = duty_q;
    period_start_d = w_boundary;
    underflow_d    = underflow_q && !clear_flags;
    overflow_d     = overflow_q  && !clear_flags;
    if (enable) cnt_d = w_boundary ? '0 : cnt_q + CNT_W'(1);
    if (w_pop) duty_d = DUTY_WIDTH'(w_prod >> DUTY_WIDTH);
    if (w_boundary && w_empty) underflow_d = 1'b1;
    if (sample_valid && w_full) overflow_d = 1'b1;
  end

  // State registers with synchronous reset to a silent, idle output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      duty_q         <= DUTY_MID;
      period_start_q <= 1'b0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
      underflow_q    <= underflow_d;
      overflow_q     <= overflow_d;
    end
  end

  assign duty_cycle   = duty_q;
  assign period_start = period_start_q;
  assign underflow    = underflow_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pwm_duty_scheduler
// Purpose  : Self-checking bench for pwm_duty_scheduler
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pwm_duty_scheduler;

  localparam int P = 192;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        sample_ready;
  logic [7:0]  duty_cycle;
  logic        period_start;
  logic [2:0]  fifo_level;
  logic        underflow;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_cnt = 0;
  logic [15:0] m_q[$];
  logic [7:0]  m_duty = 8'd96;
  logic        m_ps = 1'b0;
  logic        m_uf = 1'b0;
  logic        m_of = 1'b0;

  pwm_duty_scheduler #(
    .SAMPLE_WIDTH (16),
    .DUTY_WIDTH   (8),
    .PERIOD       (P),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .duty_cycle   (duty_cycle),
    .period_start (period_start),
    .fifo_level   (fifo_level),
    .underflow    (underflow),
    .overflow     (overflow),
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Signed sample -> 0..65535 level -> 8-bit level -> fraction of the period
  function automatic logic [7:0] ref_duty(logic [15:0] s);
    int sv;
    int t;
    sv = int'($signed(s));
    t  = (sv + 32768) / 256;
    return 8'((t * P) / 256);
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT
  task automatic tick();
    bit bnd, was_full, was_empty;
    if (rst) begin
      m_cnt = 0; m_q.delete(); m_duty = 8'(P / 2); m_ps = 0; m_uf = 0; m_of = 0;
    end else begin
      bnd       = enable && (m_cnt == P - 1);
      was_full  = (m_q.size() == D);
      was_empty = (m_q.size() == 0);
      if (bnd && !was_empty) begin
        m_duty = ref_duty(m_q[0]);
        void'(m_q.pop_front());
      end
      if (sample_valid && !was_full) m_q.push_back(sample_in);
      m_uf = (bnd && was_empty) || (m_uf && !clear_flags);
      m_of = (sample_valid && was_full) || (m_of && !clear_flags);
      m_ps = bnd;
      if (enable) m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; clear_flags = 1'b0; enable = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (duty_cycle !== 8'd96) begin n_fail++; $display("FAIL reset_duty: got %0d want 96", duty_cycle); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b want 0", period_start); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b want 0", underflow); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_of: got %b want 0", overflow); end
    tick();
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps_first: got %b want 0", period_start); end
  endtask

  task automatic test_idle_underflow();
    int pulses = 0;
    int first_uf = -1;
    int bad_duty = 0;
    do_reset();
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (duty_cycle !== 8'd96) bad_duty++;
      if (period_start === 1'b1) begin
        pulses++;
        n_checks++; if ((i % P) != 0) begin n_fail++; $display("FAIL idle_ps_pos: pulse at cycle %0d want multiple of %0d", i, P); end
      end
      if (underflow === 1'b1 && first_uf < 0) first_uf = i;
    end
    n_checks++; if (bad_duty != 0) begin n_fail++; $display("FAIL idle_duty: %0d cycles off 96 want 0", bad_duty); end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL idle_pulses: got %0d want 2", pulses); end
    n_checks++; if (first_uf != P) begin n_fail++; $display("FAIL idle_uf_cycle: got %0d want %0d", first_uf, P); end
  endtask

  task automatic test_sequence();
    logic [15:0] smp [4];
    logic [7:0]  exp_duty [5];
    logic [2:0]  exp_lvl  [5];
    int w;
    smp = '{16'h0000, 16'h7FFF, 16'h8000, 16'hC000};
    exp_duty = '{8'd96, 8'd191, 8'd0, 8'd48, 8'd48};
    exp_lvl  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1; sample_in = smp[k]; tick();
    end
    sample_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL seq_fill: got %0d want 4", fifo_level); end
    for (int b = 0; b < 5; b++) begin
      w = 0;
      do begin tick(); w++; end while (period_start !== 1'b1 && w < 2 * P);
      n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL seq_timeout: boundary %0d not seen within %0d cycles", b, w); end
      n_checks++; if (duty_cycle !== exp_duty[b]) begin n_fail++; $display("FAIL seq_duty: boundary %0d got %0d want %0d", b, duty_cycle, exp_duty[b]); end
      n_checks++; if (fifo_level !== exp_lvl[b]) begin n_fail++; $display("FAIL seq_level: boundary %0d got %0d want %0d", b, fifo_level, exp_lvl[b]); end
      n_checks++; if (underflow !== (b == 4)) begin n_fail++; $display("FAIL seq_uf: boundary %0d got %b want %b", b, underflow, (b == 4)); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    sample_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample_in = 16'($urandom);
      tick();
      if (k == 3) begin
        n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_after4: got %b want 0", sample_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    sample_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_uf: got %b want 0", underflow); end
  endtask

  task automatic test_boundary_push();
    do_reset();
    repeat (P - 1) tick();
    sample_valid = 1'b1; sample_in = 16'h7FFF;
    tick();
    sample_valid = 1'b0;
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL bpush_ps: got %b want 1", period_start); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL bpush_uf: got %b want 1", underflow); end
    n_checks++; if (duty_cycle !== 8'd96) begin n_fail++; $display("FAIL bpush_duty_hold: got %0d want 96", duty_cycle); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL bpush_level: got %0d want 1", fifo_level); end
    repeat (P - 1) tick();
    n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL bpush_early_ps: got %b want 0", period_start); end
    tick();
    n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL bpush_next_ps: got %b want 1", period_start); end
    n_checks++; if (duty_cycle !== 8'd191) begin n_fail++; $display("FAIL bpush_applied: got %0d want 191", duty_cycle); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL bpush_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_enable_hold();
    int w;
    int bad = 0;
    do_reset();
    sample_valid = 1'b1; sample_in = 16'hC000; tick();
    sample_valid = 1'b0;
    repeat (99) tick();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample_valid = (i == 10); sample_in = 16'h8000;
      tick();
      if (period_start !== 1'b0 || duty_cycle !== 8'd96) bad++;
    end
    sample_valid = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_frozen: %0d cycles changed want 0", bad); end
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL hold_push: got %0d want 2", fifo_level); end
    enable = 1'b1;
    w = 0;
    do begin tick(); w++; end while (period_start !== 1'b1 && w < 2 * P);
    n_checks++; if (w != P - 100) begin n_fail++; $display("FAIL hold_delay: boundary after %0d cycles want %0d", w, P - 100); end
    n_checks++; if (duty_cycle !== 8'd48) begin n_fail++; $display("FAIL hold_duty: got %0d want 48", duty_cycle); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL hold_level: got %0d want 1", fifo_level); end
  endtask

  task automatic test_flags();
    do_reset();
    sample_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin sample_in = 16'($urandom); tick(); end
    clear_flags = 1'b1;
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL flags_set_wins: got %b want 1", overflow); end
    sample_valid = 1'b0;
    tick();
    clear_flags = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flags_clear: got %b want 0", overflow); end
    sample_valid = 1'b1; sample_in = 16'h1234;
    rst = 1'b1;
    tick();
    rst = 1'b0; sample_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    n_checks++; if (duty_cycle !== 8'd96) begin n_fail++; $display("FAIL midrst_duty: got %0d want 96", duty_cycle); end
    n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", sample_ready); end
  endtask

  task automatic test_random();
    int rate;
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       rate = 1;
        1:       rate = 60;
        default: rate = 250;
      endcase
      for (int c = 0; c < 500; c++) begin
        rst          = ($urandom_range(0, 999) == 0);
        enable       = ($urandom_range(0, 9) != 0);
        sample_valid = ($urandom_range(0, rate) == 0);
        clear_flags  = ($urandom_range(0, 49) == 0);
        sample_in    = 16'($urandom);
        tick();
        n_checks++; if (duty_cycle !== m_duty) begin n_fail++; $display("FAIL rnd_duty: cyc %0d got %0d want %0d", c, duty_cycle, m_duty); end
        n_checks++; if (fifo_level !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_level: cyc %0d got %0d want %0d", c, fifo_level, m_q.size()); end
        n_checks++; if (sample_ready !== (m_q.size() < D)) begin n_fail++; $display("FAIL rnd_ready: cyc %0d got %b want %b", c, sample_ready, (m_q.size() < D)); end
        n_checks++; if (period_start !== m_ps) begin n_fail++; $display("FAIL rnd_ps: cyc %0d got %b want %b", c, period_start, m_ps); end
        n_checks++; if (underflow !== m_uf) begin n_fail++; $display("FAIL rnd_uf: cyc %0d got %b want %b", c, underflow, m_uf); end
        n_checks++; if (overflow !== m_of) begin n_fail++; $display("FAIL rnd_of: cyc %0d got %b want %b", c, overflow, m_of); end
      end
    end
    rst = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_underflow();
    test_sequence();
    test_overflow();
    test_boundary_push();
    test_enable_hold();
    test_flags();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
